// File: rtl/ysyx_mem_pkg.sv
// Shared constants for the memory responder: AXI response codes, FSM encodings, LFSR seed.
// No logic; imported by ysyx_mem_responder and ysyx_lfsr8.
package ysyx_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/ysyx_lfsr8.sv
// Purpose: 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter response latency.
// Latency: new value every clock; seed restored by reset.
// Backpressure: none, free-running.
module ysyx_lfsr8
    import ysyx_mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ysyx_mem_responder.sv
// Purpose: word-organised SRAM model behind AXI4-Lite-style AR/R and AW/W/B channels.
// Latency: RVALID RD_LAT cycles after AR, BVALID WR_LAT cycles after AW+W (+lfsr[2:0] with MEM_RESP_RAND_DELAY_EN).
// Backpressure: one outstanding read and one write; RVALID/BVALID held with stable payload until ready.
module ysyx_mem_responder
    import ysyx_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned       RD_LAT      = 1,
    parameter int unsigned       WR_LAT      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_W-1:0]     awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 16;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic [CNT_W-1:0] extra_dly;
`ifdef MEM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr;

    ysyx_lfsr8 u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (lfsr)
    );

    assign extra_dly = CNT_W'(lfsr[2:0]);
`else
    assign extra_dly = '0;
`endif

    // Out-of-window addresses never touch storage; the index register is don't-care for them.
    logic [ADDR_W-1:0] ar_off;
    logic [ADDR_W-1:0] aw_off;
    logic              ar_bad;
    logic              aw_bad;

    assign ar_off = (araddr_i - BASE_ADDR) >> LSB;
    assign aw_off = (awaddr_i - BASE_ADDR) >> LSB;
    assign ar_bad = (araddr_i < BASE_ADDR) || (ar_off >= ADDR_W'(DEPTH_WORDS));
    assign aw_bad = (awaddr_i < BASE_ADDR) || (aw_off >= ADDR_W'(DEPTH_WORDS));

    logic [1:0]        r_state_q, r_state_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d;
    logic              r_bad_q, r_bad_d;
    logic              arready_q, arready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_bad_d   = r_bad_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_i && arready_q) begin
                    r_state_d = R_WAIT;
                    r_cnt_d   = CNT_W'(RD_LAT - 1) + extra_dly;
                    r_idx_d   = ar_off[IDX_W-1:0];
                    r_bad_d   = ar_bad;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    r_state_d = R_RESP;
                    rdata_d   = r_bad_q ? '0 : mem_q[r_idx_q];
                    rresp_d   = r_bad_q ? RESP_DECERR : RESP_OKAY;
                end else begin
                    r_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_bad_q   <= 1'b0;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_bad_q   <= r_bad_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = (r_state_q == R_RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    logic [1:0]        w_state_q, w_state_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic              w_bad_q, w_bad_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              w_commit;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_bad_d   = w_bad_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_i && awready_q) begin
                    aw_held_d = 1'b1;
                    w_idx_d   = aw_off[IDX_W-1:0];
                    w_bad_d   = aw_bad;
                end
                if (wvalid_i && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata_i;
                    w_strb_d = wstrb_i;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = CNT_W'(WR_LAT - 1) + extra_dly;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) begin
                    w_state_d = W_RESP;
                    bresp_d   = w_bad_q ? RESP_DECERR : RESP_OKAY;
                end else begin
                    w_cnt_d = w_cnt_q - CNT_W'(1);
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            w_bad_q   <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_bad_q   <= w_bad_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = (w_state_q == W_RESP);
    assign bresp_o   = bresp_q;

    // Commit on the W_WAIT exit edge; a read sampling the same word on that edge sees the old data.
    assign w_commit = (w_state_q == W_WAIT) && (w_cnt_q == '0) && !w_bad_q;

    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) begin
                    mem_q[w_idx_q][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_mem_responder.sv
// Scoreboard bench for ysyx_mem_responder: stimulus tasks queue expected R/B responses,
// a forked monitor pops and compares them whenever a response handshakes.
module tb_ysyx_mem_responder;

    localparam int RD_LAT = 1;
    localparam int WR_LAT = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] araddr_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] awaddr_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;

    always #5 clk_i = ~clk_i;

    ysyx_mem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h8000_0000),
        .RD_LAT      (RD_LAT),
        .WR_LAT      (WR_LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .araddr_i  (araddr_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .awaddr_i  (awaddr_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      exp_r[$];
    logic [1:0] exp_b[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic monitor();
        rexp_t      e;
        logic [1:0] eb;
        forever begin
            @(negedge clk_i);
            if (!rst_i && rvalid_o && rready_i) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rdata %h with no response queued", rdata_o);
                end else begin
                    e = exp_r.pop_front();
                    check("r_data", {32'h0, rdata_o}, {32'h0, e.data});
                    check("r_resp", {62'h0, rresp_o}, {62'h0, e.resp});
                end
            end
            if (!rst_i && bvalid_o && bready_i) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bresp %b with no response queued", bresp_o);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_resp", {62'h0, bresp_o}, {62'h0, eb});
                end
            end
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        int lat;
        bit ok;
        exp_r.push_back('{data: d, resp: resp});
        araddr_i  = a;
        arvalid_i = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk_i);
            ok = arready_o;
            @(posedge clk_i);
            #1;
        end
        arvalid_i = 1'b0;
        if (!ok) begin
            timeout("ar_handshake");
            return;
        end
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 50) begin
            @(negedge clk_i);
            if (rvalid_o) begin
                ok = 1'b1;
            end else begin
                @(posedge clk_i);
                #1;
                lat++;
            end
        end
        if (!ok) begin
            timeout("r_valid");
            return;
        end
        check("r_latency", 64'(lat), 64'(RD_LAT));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input int w_lead, input int b_hold);
        bit aw_done, w_done, faw, fw, ok;
        int gap;
        int t;
        exp_b.push_back(resp);
        bready_i  = (b_hold == 0);
        awaddr_i  = a;
        wdata_i   = d;
        wstrb_i   = s;
        wvalid_i  = 1'b1;
        awvalid_i = (w_lead == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        gap = 0;
        t   = 0;
        while (!(aw_done && w_done) && t < 100) begin
            @(negedge clk_i);
            faw = awvalid_i && awready_o;
            fw  = wvalid_i && wready_o;
            @(posedge clk_i);
            #1;
            t++;
            if (faw) begin
                awvalid_i = 1'b0;
                aw_done   = 1'b1;
            end
            if (fw) begin
                wvalid_i = 1'b0;
                w_done   = 1'b1;
            end
            if (w_done && !aw_done && !awvalid_i) begin
                gap++;
                if (gap >= w_lead) awvalid_i = 1'b1;
            end
        end
        if (!(aw_done && w_done)) begin
            awvalid_i = 1'b0;
            wvalid_i  = 1'b0;
            bready_i  = 1'b1;
            timeout("aw_w_handshake");
            return;
        end
        if (b_hold > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk_i);
                ok = bvalid_o;
                if (!ok) begin
                    @(posedge clk_i);
                    #1;
                end
            end
            if (!ok) begin
                bready_i = 1'b1;
                timeout("b_valid_hold");
                return;
            end
            for (int i = 0; i < b_hold; i++) begin
                @(negedge clk_i);
                check("b_hold_valid", {63'h0, bvalid_o}, 64'h1);
                check("b_hold_resp", {62'h0, bresp_o}, {62'h0, resp});
                @(posedge clk_i);
                #1;
            end
            bready_i = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = bvalid_o && bready_i;
            @(posedge clk_i);
            #1;
        end
        if (!ok) timeout("b_handshake");
    endtask

    initial begin
        rst_i     = 1'b1;
        araddr_i  = '0;
        arvalid_i = 1'b0;
        rready_i  = 1'b1;
        awaddr_i  = '0;
        awvalid_i = 1'b0;
        wdata_i   = '0;
        wstrb_i   = '0;
        wvalid_i  = 1'b0;
        bready_i  = 1'b1;
        fork
            monitor();
            begin
                #400000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", 64'({arready_o, rvalid_o, rdata_o, rresp_o, awready_o, wready_o, bvalid_o, bresp_o}), 64'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_before_edge", {61'h0, arready_o, awready_o, wready_o}, 64'h0);
        @(posedge clk_i);
        #1;
        check("ready_after_release", {61'h0, arready_o, awready_o, wready_o}, 64'h7);

        // Full write then read back, plus ignored low address bits.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0);
        do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        do_read(32'h8000_0013, 32'hDEAD_BEEF, 2'b00);

        // Byte lanes, and an all-zero strobe.
        do_write(32'h8000_0030, 32'h1122_3344, 4'hF, 2'b00, 0, 0);
        do_write(32'h8000_0030, 32'hAABB_CCDD, 4'b0101, 2'b00, 0, 0);
        do_read(32'h8000_0030, 32'h11BB_33DD, 2'b00);
        do_write(32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 0);
        do_read(32'h8000_0030, 32'h11BB_33DD, 2'b00);

        // W leads AW by 3 cycles, B held off for 5 cycles.
        do_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF, 2'b00, 3, 5);
        do_read(32'h8000_0040, 32'hCAFE_F00D, 2'b00);

        // Decode errors; index 4096 must not alias onto word 0.
        do_write(32'h8000_0000, 32'h0A0B_0C0D, 4'hF, 2'b00, 0, 0);
        do_write(32'h8000_3FFC, 32'h7777_8888, 4'hF, 2'b00, 0, 0);
        do_read(32'h7FFF_FFFC, 32'h0, 2'b11);
        do_read(32'h8000_4000, 32'h0, 2'b11);
        do_write(32'h8000_4000, 32'h5555_5555, 4'hF, 2'b11, 0, 0);
        do_write(32'h7FFF_FFFC, 32'h6666_6666, 4'hF, 2'b11, 0, 0);
        do_read(32'h8000_0000, 32'h0A0B_0C0D, 2'b00);
        do_read(32'h8000_3FFC, 32'h7777_8888, 2'b00);

        // Read sample and write commit land on the same edge.
        do_write(32'h8000_0050, 32'h0101_0101, 4'hF, 2'b00, 0, 0);
        fork
            do_read(32'h8000_0050, 32'h0101_0101, 2'b00);
            do_write(32'h8000_0050, 32'h0202_0202, 4'hF, 2'b00, 0, 0);
        join
        do_read(32'h8000_0050, 32'h0202_0202, 2'b00);

        // Reset in the middle of a write: outputs clear at once, nothing committed.
        do_write(32'h8000_0020, 32'h1234_5678, 4'hF, 2'b00, 0, 0);
        do_read(32'h8000_0020, 32'h1234_5678, 2'b00);
        awaddr_i  = 32'h8000_0020;
        wdata_i   = 32'hFFFF_FFFF;
        wstrb_i   = 4'hF;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        rst_i     = 1'b1;
        #1;
        check("midrun_reset_outputs", 64'({arready_o, rvalid_o, rdata_o, rresp_o, awready_o, wready_o, bvalid_o, bresp_o}), 64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrun_ready_before_edge", {61'h0, arready_o, awready_o, wready_o}, 64'h0);
        @(posedge clk_i);
        #1;
        check("midrun_ready_after_release", {61'h0, arready_o, awready_o, wready_o}, 64'h7);
        check("midrun_no_bvalid", {63'h0, bvalid_o}, 64'h0);
        do_read(32'h8000_0020, 32'h1234_5678, 2'b00);

        for (int i = 0; i < 20 && (exp_r.size() != 0 || exp_b.size() != 0); i++) begin
            @(posedge clk_i);
        end
        if (exp_r.size() != 0 || exp_b.size() != 0) timeout("drain_scoreboard");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
